// File: rtl/indexed_array_forcer_pkg.sv
// indexed_array_pkg: shared error positions, override channel states and index legality check
package indexed_array_pkg;
  localparam int ERR_W = 3;
  localparam int WR_ERR = 0;
  localparam int RD_ERR = 1;
  localparam int OVR_ERR = 2;
  typedef enum logic {OVR_IDLE, OVR_ACTIVE} ovr_state_t;
  function automatic logic idx_legal(input logic [31:0] idx, input int unsigned base, input int unsigned depth);
    return !$isunknown(idx) && idx >= base && idx < base + depth;
  endfunction
endpackage

// File: rtl/indexed_array_forcer_ovr_channel.sv
// ovr_channel: one override channel holding its force state and latched target address
module ovr_channel
  import indexed_array_pkg::*;
#(
  parameter int IDX_W  = 4,
  parameter int BASE   = 1,
  parameter int DEPTH  = 2,
  parameter int ADDR_W = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              force_i,
  input  logic              rel_i,
  input  logic [IDX_W-1:0]  idx_i,
  output logic              active_o,
  output logic [ADDR_W-1:0] addr_o,
  output logic              err_o
);
  ovr_state_t state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic legal;
  // Force has priority over release; an illegal force leaves the channel untouched
  always_comb begin
    legal = idx_legal(32'(idx_i), BASE, DEPTH);
    state_d = state_q;
    addr_d = addr_q;
    if (force_i) begin
      state_d = legal ? OVR_ACTIVE : state_q;
      addr_d = legal ? ADDR_W'(idx_i - IDX_W'(BASE)) : addr_q;
    end else if (rel_i) begin
      state_d = OVR_IDLE;
    end
    err_o = force_i && !legal;
  end
  // Channel state and latched target register
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= OVR_IDLE;
      addr_q <= '0;
    end else begin
      state_q <= state_d;
      addr_q <= addr_d;
    end
  end
  assign active_o = state_q == OVR_ACTIVE;
  assign addr_o = addr_q;
endmodule

// File: rtl/indexed_array_forcer.sv
// indexed_array_forcer: bounds-checked register array with per-entry force/release override channels
module indexed_array_forcer
  import indexed_array_pkg::*;
#(
  parameter int WIDTH = 2,
  parameter int DEPTH = 2,
  parameter int BASE = 1,
  parameter int IDX_W = 4,
  parameter int NUM_OVR = 2,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     wr_en,
  input  logic [IDX_W-1:0]         wr_idx,
  input  logic [WIDTH-1:0]         wr_data,
  input  logic [IDX_W-1:0]         rd_idx,
  output logic [WIDTH-1:0]         rd_data,
  output logic                     rd_oor,
  input  logic [NUM_OVR-1:0]       ovr_force,
  input  logic [NUM_OVR-1:0]       ovr_rel,
  input  logic [NUM_OVR*IDX_W-1:0] ovr_idx,
  input  logic [NUM_OVR*WIDTH-1:0] ovr_data,
  output logic [NUM_OVR-1:0]       ovr_active,
  output logic [ERR_W-1:0]         err_pulse,
  output logic [ERR_W-1:0]         err_sticky,
  input  logic                     err_clr
);
  localparam int ADDR_W = DEPTH > 1 ? $clog2(DEPTH) : 1;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [WIDTH-1:0] eff [DEPTH];
  logic [NUM_OVR-1:0] act, ovr_err;
  logic [ADDR_W-1:0] ovr_addr [NUM_OVR];
  logic wr_legal, rd_legal;
  logic [ADDR_W-1:0] wr_addr, rd_addr;
  logic [WIDTH-1:0] rd_data_q, rd_data_d;
  logic rd_oor_q, rd_oor_d;
  logic [ERR_W-1:0] err_pulse_q, err_pulse_d, err_sticky_q, err_sticky_d;

  for (genvar g = 0; g < NUM_OVR; g++) begin : g_ch
    ovr_channel #(.IDX_W(IDX_W), .BASE(BASE), .DEPTH(DEPTH), .ADDR_W(ADDR_W)) u_ch (
      .clk      (clk),
      .rst_n    (rst_n),
      .force_i  (ovr_force[g]),
      .rel_i    (ovr_rel[g]),
      .idx_i    (ovr_idx[g*IDX_W +: IDX_W]),
      .active_o (act[g]),
      .addr_o   (ovr_addr[g]),
      .err_o    (ovr_err[g])
    );
  end

  // Effective entry values: scan high to low so the lowest-numbered active channel wins
  always_comb begin
    for (int e = 0; e < DEPTH; e++) begin
      eff[e] = mem_q[e];
      for (int c = NUM_OVR - 1; c >= 0; c--)
        if (act[c] && ovr_addr[c] == ADDR_W'(e)) eff[e] = ovr_data[c*WIDTH +: WIDTH];
    end
  end

  // Index decode, storage update, read capture and error bookkeeping
  always_comb begin
    wr_legal = idx_legal(32'(wr_idx), BASE, DEPTH);
    rd_legal = idx_legal(32'(rd_idx), BASE, DEPTH);
    wr_addr = ADDR_W'(wr_idx - IDX_W'(BASE));
    rd_addr = ADDR_W'(rd_idx - IDX_W'(BASE));
    mem_d = mem_q;
    if (wr_en && wr_legal) mem_d[wr_addr] = wr_data;
    rd_data_d = rd_legal ? eff[rd_addr] : '0;
    rd_oor_d = !rd_legal;
    err_pulse_d = '0;
    err_pulse_d[WR_ERR] = wr_en && !wr_legal;
    err_pulse_d[RD_ERR] = !rd_legal;
    err_pulse_d[OVR_ERR] = |ovr_err;
    err_sticky_d = (err_clr ? '0 : err_sticky_q) | err_pulse_d;
  end

  // Storage, read and error registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      mem_q <= '{default: RESET_VAL};
      rd_data_q <= '0;
      rd_oor_q <= 1'b0;
      err_pulse_q <= '0;
      err_sticky_q <= '0;
    end else begin
      mem_q <= mem_d;
      rd_data_q <= rd_data_d;
      rd_oor_q <= rd_oor_d;
      err_pulse_q <= err_pulse_d;
      err_sticky_q <= err_sticky_d;
    end
  end

  assign rd_data = rd_data_q;
  assign rd_oor = rd_oor_q;
  assign ovr_active = act;
  assign err_pulse = err_pulse_q;
  assign err_sticky = err_sticky_q;
endmodule

// File: tb/tb_indexed_array_forcer.sv
// tb_indexed_array_forcer: directed scenario tests for indexed_array_forcer
module tb_indexed_array_forcer;
  logic clk = 0, rst_n = 0, wr_en = 0, err_clr = 0, rd_oor;
  logic [3:0] wr_idx = 0, rd_idx = 1, idx0 = 0, idx1 = 0;
  logic [1:0] wr_data = 0, rd_data, d0 = 0, d1 = 0, ovr_force = 0, ovr_rel = 0, ovr_active;
  logic [2:0] err_pulse, err_sticky;
  int pass = 0, total = 0;

  always #5 clk = ~clk;

  indexed_array_forcer dut (
    .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_idx(wr_idx), .wr_data(wr_data),
    .rd_idx(rd_idx), .rd_data(rd_data), .rd_oor(rd_oor), .ovr_force(ovr_force),
    .ovr_rel(ovr_rel), .ovr_idx({idx1, idx0}), .ovr_data({d1, d0}),
    .ovr_active(ovr_active), .err_pulse(err_pulse), .err_sticky(err_sticky), .err_clr(err_clr)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_err();
    err_clr = 1; step(); err_clr = 0;
  endtask

  task automatic test_reset();
    rst_n = 0; step(); step();
    total++; if (ovr_active !== 2'b00) $display("FAIL reset_active got %b exp 00", ovr_active); else pass++;
    total++; if (rd_data !== 2'd0) $display("FAIL reset_rd_data got %0d exp 0", rd_data); else pass++;
    total++; if (rd_oor !== 1'b0) $display("FAIL reset_rd_oor got %b exp 0", rd_oor); else pass++;
    total++; if (err_pulse !== 3'b000) $display("FAIL reset_err_pulse got %b exp 000", err_pulse); else pass++;
    total++; if (err_sticky !== 3'b000) $display("FAIL reset_err_sticky got %b exp 000", err_sticky); else pass++;
    rst_n = 1; step();
  endtask

  task automatic test_illegal_force();
    idx0 = 0; d0 = 1; ovr_force = 2'b01; step(); ovr_force = 0;
    total++; if (err_pulse !== 3'b100) $display("FAIL illf_err got %b exp 100", err_pulse); else pass++;
    total++; if (ovr_active !== 2'b00) $display("FAIL illf_active got %b exp 00", ovr_active); else pass++;
    rd_idx = 1; step();
    total++; if (rd_data !== 2'd0) $display("FAIL illf_rd1 got %0d exp 0", rd_data); else pass++;
    rd_idx = 2; step();
    total++; if (rd_data !== 2'd0) $display("FAIL illf_rd2 got %0d exp 0", rd_data); else pass++;
    clear_err();
  endtask

  task automatic test_force_release();
    idx0 = 1; d0 = 1; ovr_force = 2'b01; step(); ovr_force = 0;
    total++; if (ovr_active !== 2'b01) $display("FAIL fr_active got %b exp 01", ovr_active); else pass++;
    rd_idx = 1; step();
    total++; if (rd_data !== 2'd1) $display("FAIL fr_rd1 got %0d exp 1", rd_data); else pass++;
    rd_idx = 2; step();
    total++; if (rd_data !== 2'd0) $display("FAIL fr_rd2 got %0d exp 0", rd_data); else pass++;
    rd_idx = 1; ovr_rel = 2'b01; step(); ovr_rel = 0;
    total++; if (ovr_active !== 2'b00) $display("FAIL fr_rel_active got %b exp 00", ovr_active); else pass++;
    step();
    total++; if (rd_data !== 2'd0) $display("FAIL fr_rel_rd1 got %0d exp 0", rd_data); else pass++;
  endtask

  task automatic test_live_data();
    idx1 = 2; d1 = 1; ovr_force = 2'b10; step(); ovr_force = 0;
    rd_idx = 2; step();
    total++; if (rd_data !== 2'd1) $display("FAIL live_rd_a got %0d exp 1", rd_data); else pass++;
    d1 = 2; step();
    total++; if (rd_data !== 2'd2) $display("FAIL live_rd_b got %0d exp 2", rd_data); else pass++;
    rd_idx = 1; step();
    total++; if (rd_data !== 2'd0) $display("FAIL live_rd1 got %0d exp 0", rd_data); else pass++;
    rd_idx = 2; wr_en = 1; wr_idx = 2; wr_data = 3; step(); wr_en = 0; step();
    total++; if (rd_data !== 2'd2) $display("FAIL live_hidden got %0d exp 2", rd_data); else pass++;
    ovr_rel = 2'b10; step(); ovr_rel = 0; step();
    total++; if (rd_data !== 2'd3) $display("FAIL live_revert got %0d exp 3", rd_data); else pass++;
  endtask

  task automatic test_oor();
    wr_en = 1; wr_idx = 3; wr_data = 1; rd_idx = 3; step(); wr_en = 0;
    total++; if (err_pulse !== 3'b011) $display("FAIL oor_pulse got %b exp 011", err_pulse); else pass++;
    total++; if (rd_oor !== 1'b1) $display("FAIL oor_flag got %b exp 1", rd_oor); else pass++;
    total++; if (rd_data !== 2'd0) $display("FAIL oor_data got %0d exp 0", rd_data); else pass++;
    rd_idx = 1; step();
    total++; if (err_pulse !== 3'b000) $display("FAIL oor_pulse_clr got %b exp 000", err_pulse); else pass++;
    total++; if (err_sticky !== 3'b011) $display("FAIL oor_sticky got %b exp 011", err_sticky); else pass++;
    total++; if (rd_data !== 2'd0) $display("FAIL oor_rd1 got %0d exp 0", rd_data); else pass++;
    rd_idx = 2; step();
    total++; if (rd_data !== 2'd3) $display("FAIL oor_rd2 got %0d exp 3", rd_data); else pass++;
    err_clr = 1; step(); err_clr = 0;
    total++; if (err_sticky !== 3'b000) $display("FAIL oor_sticky_clr got %b exp 000", err_sticky); else pass++;
  endtask

  task automatic test_unknown_idx();
    wr_en = 1; wr_idx = 'x; wr_data = 2; idx0 = 'x; d0 = 2; ovr_force = 2'b01; rd_idx = 'x; step();
    wr_en = 0; ovr_force = 0; idx0 = 0;
    total++; if (err_pulse !== 3'b111) $display("FAIL x_pulse got %b exp 111", err_pulse); else pass++;
    total++; if (ovr_active !== 2'b00) $display("FAIL x_active got %b exp 00", ovr_active); else pass++;
    total++; if (rd_oor !== 1'b1) $display("FAIL x_oor got %b exp 1", rd_oor); else pass++;
    rd_idx = 1; step();
    total++; if (rd_data !== 2'd0) $display("FAIL x_rd1 got %0d exp 0", rd_data); else pass++;
    rd_idx = 2; step();
    total++; if (rd_data !== 2'd3) $display("FAIL x_rd2 got %0d exp 3", rd_data); else pass++;
    clear_err();
  endtask

  task automatic test_write();
    wr_en = 1; wr_idx = 1; wr_data = 2; rd_idx = 1; step(); wr_en = 0;
    total++; if (rd_data !== 2'd0) $display("FAIL wr_rbw got %0d exp 0", rd_data); else pass++;
    step();
    total++; if (rd_data !== 2'd2) $display("FAIL wr_rd1 got %0d exp 2", rd_data); else pass++;
  endtask

  task automatic test_priority_reset();
    idx0 = 1; idx1 = 1; d0 = 1; d1 = 3; ovr_force = 2'b11; rd_idx = 1; step(); ovr_force = 0;
    total++; if (ovr_active !== 2'b11) $display("FAIL pri_active got %b exp 11", ovr_active); else pass++;
    step();
    total++; if (rd_data !== 2'd1) $display("FAIL pri_rd got %0d exp 1", rd_data); else pass++;
    ovr_force = 2'b01; ovr_rel = 2'b01; step(); ovr_force = 0; ovr_rel = 0;
    total++; if (ovr_active !== 2'b11) $display("FAIL pri_frc_rel got %b exp 11", ovr_active); else pass++;
    ovr_rel = 2'b01; step(); ovr_rel = 0; step();
    total++; if (rd_data !== 2'd3) $display("FAIL pri_ch1 got %0d exp 3", rd_data); else pass++;
    wr_en = 1; wr_idx = 0; rd_idx = 2; step(); wr_en = 0;
    total++; if (err_sticky !== 3'b001) $display("FAIL pri_sticky got %b exp 001", err_sticky); else pass++;
    rst_n = 0; step(); rst_n = 1;
    total++; if (ovr_active !== 2'b00) $display("FAIL rst_active got %b exp 00", ovr_active); else pass++;
    total++; if (err_sticky !== 3'b000) $display("FAIL rst_sticky got %b exp 000", err_sticky); else pass++;
    total++; if (rd_data !== 2'd0) $display("FAIL rst_rd got %0d exp 0", rd_data); else pass++;
    rd_idx = 1; step();
    total++; if (rd_data !== 2'd0) $display("FAIL rst_rd1 got %0d exp 0", rd_data); else pass++;
    rd_idx = 2; step();
    total++; if (rd_data !== 2'd0) $display("FAIL rst_rd2 got %0d exp 0", rd_data); else pass++;
  endtask

  initial begin
    test_reset();
    test_illegal_force();
    test_force_release();
    test_live_data();
    test_oor();
    test_unknown_idx();
    test_write();
    test_priority_reset();
    $display("%0d/%0d checks passed", pass, total);
    $finish;
  end
endmodule
